// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared paddle geometry, coordinate type, FSM states and clamp helper
//
// Shared by the paddle position block and the pixel-color block so both use
// identical box limits.

package paddle_pkg;

    typedef logic [15:0] coord_t;

    localparam int SCREEN_W_DEF     = 640;
    localparam int SCREEN_H_DEF     = 480;
    localparam int PAD_W_DEF        = 102;
    localparam int PAD_H_DEF        = 76;
    localparam int HALF_W           = PAD_W_DEF / 2;
    localparam int HALF_H           = PAD_H_DEF / 2;
    localparam int X_MAX            = SCREEN_W_DEF - PAD_W_DEF;
    localparam int Y_MAX            = SCREEN_H_DEF - PAD_H_DEF;
    localparam int MAX_STEP_DEF     = 16;
    localparam int X_RESET_DEF      = 269;
    localparam int Y_RESET_DEF      = 202;
    localparam int STALE_FRAMES_DEF = 60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        STEP  = 2'd2
    } state_t;

    // Converts a requested centre coordinate into a top-left corner that keeps
    // the box on screen. The subtraction is done one bit wider so a borrow is
    // visible and clamps to zero instead of wrapping to a huge value.
    function automatic coord_t clamp_coord(input coord_t raw, input coord_t half,
                                           input coord_t max_val);
        logic [16:0] diff;
        coord_t      res;
        diff = {1'b0, raw} - {1'b0, half};
        if (diff[16]) begin
            res = '0;
        end else if (diff[15:0] > max_val) begin
            res = max_val;
        end else begin
            res = diff[15:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/paddle_axis_slew.sv
// rtl/paddle_axis_slew.sv - one-axis rate-limited step toward a target
//
// Ports:
//   cur       current coordinate
//   tgt       target coordinate
//   max_step  largest allowed move in one step
//   nxt       coordinate after one step toward tgt
//   at_target cur already equals tgt (no movement needed)
// Purely combinational.

module paddle_axis_slew
    import paddle_pkg::*;
(
    input  coord_t cur,
    input  coord_t tgt,
    input  coord_t max_step,
    output coord_t nxt,
    output logic   at_target
);

    always_comb begin
        nxt       = tgt;
        at_target = (cur == tgt);
        if (tgt > cur) begin
            if ((tgt - cur) > max_step) begin
                nxt = cur + max_step;
            end
        end else begin
            if ((cur - tgt) > max_step) begin
                nxt = cur - max_step;
            end
        end
    end

endmodule

// File: rtl/paddle_pos_sync.sv
// rtl/paddle_pos_sync.sv - frame-synchronous, clamped and slew-limited paddle position
//
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   in_x, in_y      requested paddle centre (valid/ready handshake)
//   in_valid        sample valid
//   in_ready        sample can be accepted (low only during the STEP cycle)
//   frame_start     one-cycle pulse at start of vertical blanking
//   x_loc, y_loc    committed top-left corner of the paddle box
//   loc_updated     one-cycle pulse coincident with a change of x_loc/y_loc
//   stale           no sample accepted for STALE_FRAMES frames

module paddle_pos_sync
    import paddle_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int PAD_W        = PAD_W_DEF,
    parameter int PAD_H        = PAD_H_DEF,
    parameter int MAX_STEP     = MAX_STEP_DEF,
    parameter int X_RESET      = X_RESET_DEF,
    parameter int Y_RESET      = Y_RESET_DEF,
    parameter int STALE_FRAMES = STALE_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        frame_start,
    output logic [15:0] x_loc,
    output logic [15:0] y_loc,
    output logic        loc_updated,
    output logic        stale
);

    localparam int CNT_W = $clog2(STALE_FRAMES + 1);

    localparam coord_t HALF_W_C   = coord_t'(PAD_W / 2);
    localparam coord_t HALF_H_C   = coord_t'(PAD_H / 2);
    localparam coord_t X_MAX_C    = coord_t'(SCREEN_W - PAD_W);
    localparam coord_t Y_MAX_C    = coord_t'(SCREEN_H - PAD_H);
    localparam coord_t MAX_STEP_C = coord_t'(MAX_STEP);
    localparam coord_t X_RESET_C  = coord_t'(X_RESET);
    localparam coord_t Y_RESET_C  = coord_t'(Y_RESET);

    localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    coord_t           x_loc_q, x_loc_d;
    coord_t           y_loc_q, y_loc_d;
    coord_t           tgt_x_q, tgt_x_d;
    coord_t           tgt_y_q, tgt_y_d;
    coord_t           step_x_q, step_x_d;
    coord_t           step_y_q, step_y_d;
    logic             loc_updated_q, loc_updated_d;
    logic             in_ready_q, in_ready_d;
    logic             stale_q, stale_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic   accept;
    coord_t clamp_x, clamp_y;
    coord_t slew_cur_x, slew_cur_y;
    coord_t slew_nxt_x, slew_nxt_y;
    logic   at_x, at_y;

    assign accept  = in_valid && in_ready_q;
    assign clamp_x = clamp_coord(in_x, HALF_W_C, X_MAX_C);
    assign clamp_y = clamp_coord(in_y, HALF_H_C, Y_MAX_C);

    // During STEP the slew units look at the position about to be committed so
    // at_target tells whether the move finishes the trip; otherwise they look
    // at the committed position.
    assign slew_cur_x = (state_q == STEP) ? step_x_q : x_loc_q;
    assign slew_cur_y = (state_q == STEP) ? step_y_q : y_loc_q;

    paddle_axis_slew u_slew_x (
        .cur       (slew_cur_x),
        .tgt       (tgt_x_q),
        .max_step  (MAX_STEP_C),
        .nxt       (slew_nxt_x),
        .at_target (at_x)
    );

    paddle_axis_slew u_slew_y (
        .cur       (slew_cur_y),
        .tgt       (tgt_y_q),
        .max_step  (MAX_STEP_C),
        .nxt       (slew_nxt_y),
        .at_target (at_y)
    );

    always_comb begin
        state_d       = state_q;
        x_loc_d       = x_loc_q;
        y_loc_d       = y_loc_q;
        tgt_x_d       = tgt_x_q;
        tgt_y_d       = tgt_y_q;
        step_x_d      = step_x_q;
        step_y_d      = step_y_q;
        loc_updated_d = 1'b0;
        seen_d        = seen_q;
        cnt_d         = cnt_q;

        case (state_q)
            IDLE: begin
                if (!(at_x && at_y)) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                // The step is latched from the target held before this edge,
                // so a sample arriving with frame_start waits for the next frame.
                if (frame_start) begin
                    step_x_d = slew_nxt_x;
                    step_y_d = slew_nxt_y;
                    state_d  = STEP;
                end
            end
            STEP: begin
                x_loc_d       = step_x_q;
                y_loc_d       = step_y_q;
                loc_updated_d = (step_x_q != x_loc_q) || (step_y_q != y_loc_q);
                state_d       = (at_x && at_y) ? IDLE : TRACK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            tgt_x_d = clamp_x;
            tgt_y_d = clamp_y;
        end

        // seen_q remembers a sample accepted since the last frame_start, so a
        // frame that had input does not count toward staleness.
        if (accept) begin
            cnt_d  = '0;
            seen_d = !frame_start;
        end else if (frame_start) begin
            if (!seen_q && (cnt_q != STALE_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            seen_d = 1'b0;
        end

        stale_d    = (cnt_d == STALE_MAX);
        in_ready_d = (state_d != STEP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            x_loc_q       <= X_RESET_C;
            y_loc_q       <= Y_RESET_C;
            tgt_x_q       <= X_RESET_C;
            tgt_y_q       <= Y_RESET_C;
            step_x_q      <= X_RESET_C;
            step_y_q      <= Y_RESET_C;
            loc_updated_q <= 1'b0;
            in_ready_q    <= 1'b1;
            stale_q       <= 1'b0;
            seen_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            x_loc_q       <= x_loc_d;
            y_loc_q       <= y_loc_d;
            tgt_x_q       <= tgt_x_d;
            tgt_y_q       <= tgt_y_d;
            step_x_q      <= step_x_d;
            step_y_q      <= step_y_d;
            loc_updated_q <= loc_updated_d;
            in_ready_q    <= in_ready_d;
            stale_q       <= stale_d;
            seen_q        <= seen_d;
            cnt_q         <= cnt_d;
        end
    end

    assign x_loc       = x_loc_q;
    assign y_loc       = y_loc_q;
    assign loc_updated = loc_updated_q;
    assign in_ready    = in_ready_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_paddle_pos_sync.sv
// tb/tb_paddle_pos_sync.sv - self-checking bench for paddle_pos_sync

module tb_paddle_pos_sync;

    logic        clk;
    logic        rst;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        in_valid;
    logic        in_ready;
    logic        frame_start;
    logic [15:0] x_loc;
    logic [15:0] y_loc;
    logic        loc_updated;
    logic        stale;

    int checks   = 0;
    int failures = 0;

    paddle_pos_sync dut (
        .clk         (clk),
        .rst         (rst),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_start (frame_start),
        .x_loc       (x_loc),
        .y_loc       (y_loc),
        .loc_updated (loc_updated),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_x, m_y, m_tx, m_ty, m_sx, m_sy, m_cnt;
    bit  m_moving, m_stepping, m_upd, m_stale, m_seen, model_ok;

    function automatic int clamp_i(input int v, input int half, input int mx);
        int t;
        t = v - half;
        if (t < 0) return 0;
        if (t > mx) return mx;
        return t;
    endfunction

    function automatic int slew_i(input int c, input int t);
        if (t - c > 16) return c + 16;
        if (c - t > 16) return c - 16;
        return t;
    endfunction

    initial model_ok = 1'b0;

    always @(posedge clk) begin
        bit acc;
        if (!rst) begin
            m_x = 269; m_y = 202; m_tx = 269; m_ty = 202;
            m_moving = 0; m_stepping = 0; m_upd = 0;
            m_cnt = 0; m_seen = 0; m_stale = 0;
            model_ok = 1'b1;
        end else begin
            acc   = in_valid && !m_stepping;
            m_upd = 0;
            if (m_stepping) begin
                m_upd      = (m_sx != m_x) || (m_sy != m_y);
                m_x        = m_sx;
                m_y        = m_sy;
                m_stepping = 0;
                m_moving   = (m_x != m_tx) || (m_y != m_ty);
            end else if (m_moving) begin
                if (frame_start) begin
                    m_sx       = slew_i(m_x, m_tx);
                    m_sy       = slew_i(m_y, m_ty);
                    m_stepping = 1;
                end
            end else begin
                m_moving = (m_x != m_tx) || (m_y != m_ty);
            end
            if (acc) begin
                m_cnt  = 0;
                m_seen = !frame_start;
                m_tx   = clamp_i(int'(in_x), 51, 538);
                m_ty   = clamp_i(int'(in_y), 38, 404);
            end else if (frame_start) begin
                if (!m_seen && m_cnt < 60) m_cnt = m_cnt + 1;
                m_seen = 0;
            end
            m_stale = (m_cnt == 60);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_x_loc", int'(x_loc), m_x);
            chk("model_y_loc", int'(y_loc), m_y);
            chk("model_loc_updated", int'(loc_updated), int'(m_upd));
            chk("model_stale", int'(stale), int'(m_stale));
            chk("model_in_ready", int'(in_ready), int'(!m_stepping));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit v, input int x, input int y, input bit fs);
        in_valid    = v;
        in_x        = 16'(x);
        in_y        = 16'(y);
        frame_start = fs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);
    endtask

    function automatic int rnd_coord();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 65535));
            1:       return int'($urandom_range(0, 700));
            2:       return int'($urandom_range(0, 60));
            default: return int'($urandom_range(600, 65535));
        endcase
    endfunction

    initial begin
        rst = 1'b0; in_valid = 0; in_x = 0; in_y = 0; frame_start = 0;

        // reset state
        do_reset();
        chk("reset_x", int'(x_loc), 269);
        chk("reset_y", int'(y_loc), 202);
        chk("reset_ready", int'(in_ready), 1);
        chk("reset_upd", int'(loc_updated), 0);
        chk("reset_stale", int'(stale), 0);

        // centre sample maps onto the reset corner: nothing moves
        cyc(1, 320, 240, 0);
        idle(2);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("centre_upd", int'(loc_updated), 0);
            chk("centre_x", int'(x_loc), 269);
        end

        // clamp and slew toward (0,404)
        do_reset();
        cyc(1, 10, 470, 0);
        idle(2);
        for (int f = 1; f <= 17; f++) begin
            cyc(0, 0, 0, 1);
            chk("slew_ready_step", int'(in_ready), 0);
            idle(1);
            chk("slew_upd", int'(loc_updated), 1);
            chk("slew_x", int'(x_loc), (269 - 16 * f < 0) ? 0 : 269 - 16 * f);
            chk("slew_y", int'(y_loc), (202 + 16 * f > 404) ? 404 : 202 + 16 * f);
            if (f == 1) begin
                chk("frame1_x", int'(x_loc), 253);
                chk("frame1_y", int'(y_loc), 218);
            end
            if (f == 13) chk("y_arrive", int'(y_loc), 404);
            idle(2);
        end
        chk("x_arrive", int'(x_loc), 0);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("arrived_upd", int'(loc_updated), 0);
        end

        // sample arriving with frame_start uses the old target for this step
        do_reset();
        cyc(1, 10, 470, 0);
        idle(2);
        cyc(0, 0, 0, 1);
        idle(3);
        cyc(1, 600, 300, 1);
        chk("simul_ready_step", int'(in_ready), 0);
        idle(1);
        chk("simul_ready_after", int'(in_ready), 1);
        chk("simul_x", int'(x_loc), 237);
        chk("simul_y", int'(y_loc), 234);
        idle(2);
        cyc(0, 0, 0, 1);
        idle(1);
        chk("simul_next_x", int'(x_loc), 253);
        chk("simul_next_y", int'(y_loc), 250);

        // low-side clamp: (0,0) must not wrap
        do_reset();
        cyc(1, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 1);
        idle(1);
        chk("low_x", int'(x_loc), 253);
        chk("low_y", int'(y_loc), 186);

        // high-side clamp
        do_reset();
        cyc(1, 65535, 65535, 0);
        idle(2);
        cyc(0, 0, 0, 1);
        idle(1);
        chk("high_x", int'(x_loc), 285);
        chk("high_y", int'(y_loc), 218);
        repeat (20) begin
            cyc(0, 0, 0, 1);
            idle(3);
        end
        chk("high_final_x", int'(x_loc), 538);
        chk("high_final_y", int'(y_loc), 404);

        // stale after exactly 60 quiet frames
        do_reset();
        for (int f = 1; f <= 60; f++) begin
            cyc(0, 0, 0, 1);
            if (f == 59) chk("stale_59", int'(stale), 0);
            if (f == 60) chk("stale_60", int'(stale), 1);
            idle(2);
        end
        cyc(1, 320, 240, 0);
        chk("stale_cleared", int'(stale), 0);
        cyc(0, 0, 0, 1);
        chk("stale_after_fs", int'(stale), 0);

        // reset during STEP
        do_reset();
        cyc(1, 10, 470, 0);
        idle(2);
        cyc(0, 0, 0, 1);
        rst = 1'b0;
        idle(1);
        chk("rst_step_x", int'(x_loc), 269);
        chk("rst_step_y", int'(y_loc), 202);
        chk("rst_step_upd", int'(loc_updated), 0);
        chk("rst_step_ready", int'(in_ready), 1);
        rst = 1'b1;
        idle(1);
        cyc(0, 0, 0, 1);
        idle(3);
        chk("rst_step_hold_x", int'(x_loc), 269);

        // reset during TRACK
        cyc(1, 10, 470, 0);
        idle(2);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        cyc(0, 0, 0, 1);
        idle(2);
        chk("rst_track_x", int'(x_loc), 269);
        chk("rst_track_upd", int'(loc_updated), 0);

        // randomized traffic against the model
        for (int i = 0; i < 5000; i++) begin
            rst = ($urandom_range(0, 599) != 0);
            cyc(($urandom_range(0, 5) == 0), rnd_coord(), rnd_coord(),
                ($urandom_range(0, 8) == 0));
        end
        rst = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/paddle_pos_sync.md
Name: paddle_pos_sync

Overview:
- Upstream stage of the paddle renderer; produces the registered `x_loc`/`y_loc` top-left corner that the pixel-color block consumes.
- Accepts raw paddle-centre samples (mouse or network) through a valid/ready handshake and clamps them so the 102x76 paddle box stays on screen.
- Commits position only at frame start, so one frame never shows two positions (no tearing).
- Limits per-frame motion to a maximum step and flags a stale input source.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- PAD_W, 102, paddle box width (x_diff range 0..101)
- PAD_H, 76, paddle box height (y_diff range 0..75)
- MAX_STEP, 16, maximum per-axis movement per frame, in pixels
- X_RESET, 269, x_loc after reset
- Y_RESET, 202, y_loc after reset
- STALE_FRAMES, 60, count of frames without an accepted sample before `stale` asserts

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- in_x  in  16  requested paddle centre x, unsigned
- in_y  in  16  requested paddle centre y, unsigned
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- x_loc  out  16  committed paddle left edge
- y_loc  out  16  committed paddle top edge
- loc_updated  out  1  one-cycle pulse; x_loc/y_loc changed this cycle
- stale  out  1  no sample accepted for STALE_FRAMES frames

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-low; it is sampled only on the rising edge of `clk`, and `rst`=0 resets the block.
- Reset values:
  - x_loc=X_RESET, y_loc=Y_RESET; target registers equal the same values.
  - loc_updated=0, stale=0, stale counter=0, state=IDLE, in_ready=1.
  - Reset mid-operation discards any pending target or step.
- Handshake:
  - A sample is accepted when in_valid && in_ready at a clock edge.
  - in_ready=0 only in state STEP; in_ready=1 in every other state.
  - There is no input buffering: each newer accepted sample overwrites the target.
- Clamp, computed in 17 bits:
  - tx = in_x - PAD_W/2 (51). If the subtraction borrows, tx=0; else if tx > SCREEN_W-PAD_W (538), tx=538.
  - ty = in_y - PAD_H/2 (38). If it borrows, ty=0; else if ty > SCREEN_H-PAD_H (404), ty=404.
  - The target registers load tx/ty on the edge that accepts the sample (1-cycle latency).
- State machine:
  - IDLE: target equals current position. A target that differs from current moves the block to TRACK.
  - TRACK: on frame_start, go to STEP. A sample accepted in the same cycle updates the target, but the step uses the target held before that edge.
  - STEP (exactly one cycle), applied per axis:
    - If |target-cur| <= MAX_STEP, cur=target.
    - Else cur moves MAX_STEP toward target.
    - x_loc/y_loc register the new values at the end of STEP; loc_updated=1 in the following cycle, coincident with the new values.
    - Next state is IDLE if the new position equals the target, else TRACK.
- frame_start in IDLE or STEP: no position change, and loc_updated stays 0.
- Position latency: x_loc changes 2 cycles after the frame_start cycle. It never changes outside that window.
- Stale counter:
  - Increments on each frame_start with no sample accepted since the previous frame_start; saturates at STALE_FRAMES.
  - stale = (count==STALE_FRAMES).
  - Any accepted sample clears the count and stale on the next edge.
  - A sample accepted in the same cycle as frame_start counts as accepted: the counter clears.
- Outputs never exceed their bounds: x_loc <= 538, y_loc <= 404 at all times, including after reset.

Decomposition:
- Shared package `paddle_pkg` holds:
  - screen and paddle dimension constants, half-widths (51, 38) and derived X_MAX/Y_MAX;
  - the state enum {IDLE, TRACK, STEP};
  - the 16-bit coordinate typedef.
  - The pixel-color block is to take its box limits from the same package.
- One sub-module `paddle_axis_slew`, instantiated twice (x and y):
  - inputs: current value, target, MAX_STEP;
  - outputs: next value and an `at_target` flag;
  - purely combinational.
- Clamp logic and the FSM stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release → x_loc=269, y_loc=202, in_ready=1, loc_updated=0, stale=0.
- Centre sample: sample (320,240), then frame_start → target (269,202) equals current; state stays IDLE; no loc_updated pulse.
- Clamp and slew: sample (10,470) → target (0,404). Each frame_start steps x by -16 and y by +16; after frame 1 position is (253,218). y reaches 404 after 13 frames; x reaches 0 after 17 frames. loc_updated pulses once per changing frame, 2 cycles after frame_start.
- Low-side clamp: sample (0,0) → target (0,0), with no wrap to 65485.
- High-side clamp: sample (65535,65535) → target (538,404).
- Simultaneous events: sample (600,300) accepted in the same cycle as frame_start while in TRACK toward (0,404) → that step still moves toward (0,404). The next frame moves toward (538,262). in_ready=0 for exactly the STEP cycle.
- Stale: no samples for 60 frame_start pulses → stale=1 after pulse 60, not after 59. One accepted sample → stale=0 on the next edge.
- Reset mid-track: rst=0 during TRACK, including in a STEP cycle → next cycle shows (269,202), IDLE, loc_updated=0.
